// File: rtl/alu_op_sequencer.sv
// Valid/ready sequencer for a combinational ALU: it latches a command, waits for the ALU to settle, captures the result and offers it as a response.
// Optional macro ALU_SELF_CHECK_EN adds a reference model whose result drives rsp_mismatch.
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [3:0]       rsp_sel,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] txn_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [3:0]       rsp_sel_q, rsp_sel_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_sel_q    <= '0;
      txn_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sel_q    <= rsp_sel_d;
      txn_count_q  <= txn_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sel_d    = rsp_sel_q;
    txn_count_d  = txn_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = req_sel;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        rsp_result_d = alu_out;
        rsp_carry_d  = alu_carry;
        rsp_sel_d    = alu_sel_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SELF_CHECK_EN
  logic [WIDTH:0]     ref_sum;
  logic [2*WIDTH-1:0] ref_prod;
  logic [WIDTH-1:0]   ref_res;
  logic               mm_q, mm_d;

  always_comb begin
    ref_sum  = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    ref_prod = {{WIDTH{1'b0}}, alu_a_q} * {{WIDTH{1'b0}}, alu_b_q};
    case (alu_sel_q)
      4'd0:    ref_res = ref_sum[WIDTH-1:0];
      4'd1:    ref_res = alu_a_q - alu_b_q;
      4'd2:    ref_res = ref_prod[WIDTH-1:0];
      4'd3:    ref_res = (alu_b_q == '0) ? '0 : alu_a_q / alu_b_q;
      4'd4:    ref_res = alu_a_q << 1;
      4'd5:    ref_res = alu_a_q >> 1;
      4'd6:    ref_res = {alu_a_q[WIDTH-2:0], alu_a_q[WIDTH-1]};
      4'd7:    ref_res = {alu_a_q[0], alu_a_q[WIDTH-1:1]};
      4'd8:    ref_res = alu_a_q & alu_b_q;
      4'd9:    ref_res = alu_a_q | alu_b_q;
      4'd10:   ref_res = alu_a_q ^ alu_b_q;
      4'd11:   ref_res = ~(alu_a_q | alu_b_q);
      4'd12:   ref_res = ~(alu_a_q & alu_b_q);
      4'd13:   ref_res = ~(alu_a_q ^ alu_b_q);
      4'd14:   ref_res = (alu_a_q > alu_b_q) ? WIDTH'(1) : '0;
      default: ref_res = (alu_a_q == alu_b_q) ? WIDTH'(1) : '0;
    endcase
    mm_d = mm_q;
    if (state_q == CAPTURE) begin
      // Division by zero has no defined ALU result, so it never flags.
      if (alu_sel_q == 4'd3 && alu_b_q == '0) mm_d = 1'b0;
      else mm_d = (ref_res != alu_out) || (ref_sum[WIDTH] != alu_carry);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mm_q <= 1'b0;
    else       mm_q <= mm_d;
  end

  assign rsp_mismatch = mm_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sel    = rsp_sel_q;
  assign txn_count  = txn_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 (defaults), instance 1 (SETTLE_CYCLES=4) and instance 2 (CNT_W=4), each driving its own behavioural ALU.
module tb_alu_op_sequencer;

`ifdef ALU_SELF_CHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        [3];
  logic       req_valid  [3];
  logic       req_ready  [3];
  logic [7:0] req_a      [3];
  logic [7:0] req_b      [3];
  logic [3:0] req_sel    [3];
  logic [7:0] alu_a      [3];
  logic [7:0] alu_b      [3];
  logic [3:0] alu_sel    [3];
  logic [7:0] alu_out    [3];
  logic       alu_carry  [3];
  logic       rsp_valid  [3];
  logic       rsp_ready  [3];
  logic [7:0] rsp_result [3];
  logic       rsp_carry  [3];
  logic [3:0] rsp_sel    [3];
  logic       rsp_mm     [3];
  logic [1:0] st         [3];
  logic [15:0] txn0, txn1;
  logic [3:0]  txn2;
  logic        alu_fault;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];   // {mismatch, sel, carry, result}

  // Behavioural ALU; alu_fault zeroes the AND result.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic flt);
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'd0:    r = sum[7:0];
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    r = a << 1;
      4'd5:    r = a >> 1;
      4'd6:    r = {a[6:0], a[7]};
      4'd7:    r = {a[0], a[7:1]};
      4'd8:    r = a & b;
      4'd9:    r = a | b;
      4'd10:   r = a ^ b;
      4'd11:   r = ~(a | b);
      4'd12:   r = ~(a & b);
      4'd13:   r = ~(a ^ b);
      4'd14:   r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    if (flt && s == 4'd8) r = 8'd0;
    return {sum[8], r};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_alu
    assign {alu_carry[g], alu_out[g]} = alu_model(alu_a[g], alu_b[g], alu_sel[g], alu_fault);
  end

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_sel(req_sel[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
    .alu_out(alu_out[0]), .alu_carry(alu_carry[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_carry(rsp_carry[0]), .rsp_sel(rsp_sel[0]), .rsp_mismatch(rsp_mm[0]),
    .txn_count(txn0), .state_dbg(st[0]));

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_sel(req_sel[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
    .alu_out(alu_out[1]), .alu_carry(alu_carry[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_carry(rsp_carry[1]), .rsp_sel(rsp_sel[1]), .rsp_mismatch(rsp_mm[1]),
    .txn_count(txn1), .state_dbg(st[1]));

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_a(req_a[2]), .req_b(req_b[2]), .req_sel(req_sel[2]),
    .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_sel(alu_sel[2]),
    .alu_out(alu_out[2]), .alu_carry(alu_carry[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_result(rsp_result[2]),
    .rsp_carry(rsp_carry[2]), .rsp_sel(rsp_sel[2]), .rsp_mismatch(rsp_mm[2]),
    .txn_count(txn2), .state_dbg(st[2]));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int idx, output int k);
    k = 0;
    while (!rsp_valid[idx] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid[idx]) check("rsp_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_compare(input int idx);
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("rsp_result", rsp_result[idx], e[7:0]);
    check("rsp_carry", rsp_carry[idx], e[8]);
    check("rsp_sel", rsp_sel[idx], e[12:9]);
    check("rsp_mismatch", rsp_mm[idx], e[13]);
  endtask

  // ---------------- driver ----------------
  // One complete transaction; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input int hold, input logic [7:0] er,
                       input logic ec, input logic em, input int exp_lat);
    int k;
    logic [13:0] snap;
    @(negedge clk);
    req_a[idx] = a; req_b[idx] = b; req_sel[idx] = sel;
    req_valid[idx] = 1'b1;
    rsp_ready[idx] = (hold == 0);
    check("req_ready idle", req_ready[idx], 1'b1);
    @(posedge clk); #1;
    exp_q.push_back({em, sel, ec, er});
    check("alu_a after accept", alu_a[idx], a);
    check("alu_sel after accept", alu_sel[idx], sel);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    req_a[idx] = 8'($urandom_range(0, 255));
    req_b[idx] = 8'($urandom_range(0, 255));
    req_sel[idx] = 4'($urandom_range(0, 15));
    wait_rsp(idx, k);
    if (!rsp_valid[idx]) return;
    if (exp_lat > 0) check("rsp_valid latency", k + 1, exp_lat);
    snap = {rsp_mm[idx], rsp_sel[idx], rsp_carry[idx], rsp_result[idx]};
    for (int h = 0; h < hold; h++) begin
      check("req_ready in RESP", req_ready[idx], 1'b0);
      check("rsp stable", {rsp_valid[idx], rsp_mm[idx], rsp_sel[idx], rsp_carry[idx], rsp_result[idx]},
            {1'b1, snap});
      @(negedge clk);
    end
    rsp_ready[idx] = 1'b1;
    pop_compare(idx);
    @(posedge clk); #1;
    check("rsp_valid after handshake", rsp_valid[idx], 1'b0);
    check("alu_a held", alu_a[idx], a);
    rsp_ready[idx] = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] res;
    logic       carry;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int k;
    vecs[0]  = '{8'h0F, 8'hF0, 4'd9,  8'hFF, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 4'd0,  8'h00, 1'b1};
    vecs[2]  = '{8'h10, 8'h03, 4'd1,  8'h0D, 1'b0};
    vecs[3]  = '{8'h07, 8'h03, 4'd2,  8'h15, 1'b0};
    vecs[4]  = '{8'h64, 8'h05, 4'd3,  8'h14, 1'b0};
    vecs[5]  = '{8'h81, 8'h00, 4'd4,  8'h02, 1'b0};
    vecs[6]  = '{8'h81, 8'h00, 4'd5,  8'h40, 1'b0};
    vecs[7]  = '{8'h81, 8'h00, 4'd6,  8'h03, 1'b0};
    vecs[8]  = '{8'h81, 8'h00, 4'd7,  8'hC0, 1'b0};
    vecs[9]  = '{8'hF0, 8'h3C, 4'd8,  8'h30, 1'b1};
    vecs[10] = '{8'hF0, 8'h3C, 4'd10, 8'hCC, 1'b1};
    vecs[11] = '{8'hF0, 8'h3C, 4'd11, 8'h03, 1'b1};
    vecs[12] = '{8'h05, 8'h03, 4'd14, 8'h01, 1'b0};
    vecs[13] = '{8'h33, 8'h33, 4'd15, 8'h01, 1'b0};
    vecs[14] = '{8'hAA, 8'h55, 4'd13, 8'h00, 1'b0};
    vecs[15] = '{8'h80, 8'h80, 4'd12, 8'h7F, 1'b1};
    vecs[16] = '{8'h09, 8'h00, 4'd3,  8'h00, 1'b0};

    alu_fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      req_a[i] = 8'h5A; req_b[i] = 8'hA5; req_sel[i] = 4'd7;
    end

    // Reset values while reset is held.
    #12;
    check("reset req_ready", req_ready[0], 1'b1);
    check("reset alu ports", {alu_a[0], alu_b[0], alu_sel[0]}, 20'h0);
    check("reset rsp", {rsp_valid[0], rsp_result[0], rsp_carry[0], rsp_sel[0], rsp_mm[0]}, 15'h0);
    check("reset txn_count", txn0, 16'd0);
    check("reset state", st[0], 2'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Table of single operations, rsp_ready tied high.
    for (int i = 0; i < 17; i++)
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].sel, 0, vecs[i].res, vecs[i].carry, 1'b0, 3);
    check("txn_count after table", txn0, 16'd17);

    // Backpressure with a second request waiting behind it.
    @(negedge clk);
    req_a[0] = 8'h11; req_b[0] = 8'h22; req_sel[0] = 4'd0; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 4'd0, 1'b0, 8'h33});
    @(negedge clk);
    req_a[0] = 8'h33; req_b[0] = 8'h44; req_sel[0] = 4'd9;
    wait_rsp(0, k);
    for (int h = 0; h < 5; h++) begin
      check("bp rsp_valid", rsp_valid[0], 1'b1);
      check("bp rsp_result", rsp_result[0], 8'h33);
      check("bp req_ready", req_ready[0], 1'b0);
      check("bp alu_a not reloaded", alu_a[0], 8'h11);
      @(negedge clk);
    end
    pop_compare(0);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp released", rsp_valid[0], 1'b0);
    check("bp second not yet accepted", alu_a[0], 8'h11);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 4'd9, 1'b0, 8'h77});
    check("bp second accepted", alu_a[0], 8'h33);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, k);
    pop_compare(0);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("txn_count after bp", txn0, 16'd19);

    // Faulty ALU on AND: mismatch only flagged when the self-check model exists.
    alu_fault = 1'b1;
    do_op(0, 8'hAA, 8'hAA, 4'd8, 2, 8'h00, 1'b1, SC, 3);
    alu_fault = 1'b0;

    // SETTLE_CYCLES=4 instance.
    do_op(1, 8'd7, 8'd3, 4'd2, 0, 8'd21, 1'b0, 1'b0, 6);
    check("s4 txn_count", txn1, 16'd1);
    @(negedge clk);
    req_a[1] = 8'h12; req_b[1] = 8'h34; req_sel[1] = 4'd0; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    #2 rst[1] = 1'b1;
    #1;
    check("async reset state", st[1], 2'd0);
    check("async reset alu", {alu_a[1], alu_b[1], alu_sel[1]}, 20'h0);
    check("async reset rsp_valid", rsp_valid[1], 1'b0);
    check("async reset req_ready", req_ready[1], 1'b1);
    check("async reset txn_count", txn1, 16'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    do_op(1, 8'h40, 8'h02, 4'd1, 1, 8'h3E, 1'b0, 1'b0, 6);
    check("s4 txn after reset", txn1, 16'd1);

    // CNT_W=4 instance: 16 ops wrap the counter.
    for (int i = 0; i < 16; i++) begin
      do_op(2, 8'(i), 8'h80, 4'd9, 0, 8'(i) | 8'h80, 1'b0, 1'b0, 3);
      if (i == 14) check("cnt4 txn_count at 15", txn2, 4'd15);
    end
    check("cnt4 txn_count wrap", txn2, 4'd0);

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the ALU operand/result interface (A, B, ALU_Sel in; ALU_Out, CarryOut out).
- Accepts operation commands on a valid/ready request channel.
- Drives the operands and select onto the combinational ALU and waits a programmable settle time.
- Captures ALU_Out/CarryOut and returns them on a valid/ready response channel.
- Sits between a command source (bench driver or on-chip sequencer) and the alu instance, replacing direct interface pokes.

Parameters:
- WIDTH, 8, operand/result width (A, B, ALU_Out)
- SETTLE_CYCLES, 1, cycles ALU inputs are held stable before capture (legal range 1..15)
- CNT_W, 16, width of the completed-transaction counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  sequencer can accept a command
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_sel  in  4  ALU operation select
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  4  to ALU ALU_Sel
- alu_out  in  WIDTH  from ALU ALU_Out
- alu_carry  in  1  from ALU CarryOut
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured ALU_Out
- rsp_carry  out  1  captured CarryOut
- rsp_sel  out  4  select the result belongs to
- rsp_mismatch  out  1  self-check flag (see Optional Feature)
- txn_count  out  CNT_W  number of responses handed off

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; req_ready=1; alu_a=0, alu_b=0, alu_sel=0; rsp_valid=0; rsp_result=0; rsp_carry=0; rsp_sel=0; rsp_mismatch=0; txn_count=0; settle counter=0.
- FSM states: IDLE, SETTLE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge N:
  - Register req_a/req_b/req_sel into alu_a/alu_b/alu_sel (visible from N+1).
  - Load settle counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE: req_ready=0; ALU inputs held. Decrement the counter each cycle; at 0, go to CAPTURE.
- CAPTURE: one cycle.
  - Register alu_out→rsp_result, alu_carry→rsp_carry, alu_sel→rsp_sel.
  - Set rsp_valid=1; go to RESP.
- RESP: rsp_valid=1 and all rsp_* fields stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, txn_count+=1, go to IDLE.
- Latency: with SETTLE_CYCLES=S, accept at edge N gives rsp_valid high from N+S+2. Back-to-back throughput is one op per S+3 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_sel keep the last command's values between commands. They change only on acceptance.
- req_ready is combinational from state (IDLE only). No request is accepted while a response is pending.
- rsp_ready asserted while rsp_valid=0 is ignored.
- txn_count wraps modulo 2^CNT_W (all-ones+1 → 0).
- Reset asserted mid-operation aborts immediately: the pending response is discarded and txn_count clears.
- Values of req_* while req_valid=0 are don't-care and must not affect state.

Optional Feature:
- Macro ALU_SELF_CHECK_EN.
- Defined: an internal reference model computes the expected result from the captured operands. Select mapping:
  - 0 add, 1 sub, 2 mul (low WIDTH), 3 div (div-by-0 exempt)
  - 4 shl1, 5 shr1, 6 rotl1, 7 rotr1
  - 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor
  - 14 A>B ? 1 : 0, 15 A==B ? 1 : 0
- Expected carry is bit WIDTH of ({0,A}+{0,B}) for every select.
- rsp_mismatch is registered in CAPTURE alongside rsp_result and held through RESP. It is 1 when the result or carry differs; it is 0 for sel=3 with B=0.
- Not defined: rsp_mismatch tied to 0 and no model logic is synthesized.

Test Plan:
- Reset, then req {a=8'h0F, b=8'hF0, sel=4'b1001} with rsp_ready=1 → alu_sel=9 from N+1; rsp_valid at N+3 (S=1); rsp_result=8'hFF, rsp_carry=0, rsp_sel=9; txn_count=1.
- Add overflow a=8'hFF, b=8'h01, sel=0 → rsp_result=8'h00, rsp_carry=1; with ALU_SELF_CHECK_EN, rsp_mismatch=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable and req_ready=0 throughout; a second req_valid is held off; accepted one cycle after the handshake.
- SETTLE_CYCLES=4: a=8'd7, b=8'd3, sel=2 → rsp_result=8'd21, rsp_valid exactly at N+6.
- Reset asserted in SETTLE → outputs return to reset values asynchronously; the next command completes normally and txn_count=1.
- CNT_W=4: 16 back-to-back ops → txn_count wraps to 0. With ALU_SELF_CHECK_EN and a faulty ALU model forcing ALU_Out=0 for sel=8, a=b=8'hAA → rsp_mismatch=1.
